// File: rtl/hart_display.sv
// Register-file debug display: snapshots the selected register and shows it on
// paged 7-segment digits plus an LED bar; a debounced pushbutton cycles pages.
module hart_display #(
   parameter  int XLEN            = 32,
   parameter  int NUM_REGS        = 32,
   parameter  int NUM_DIGITS      = 6,
   parameter  int LED_WIDTH       = 10,
   parameter  int DEBOUNCE_CYCLES = 500000,
   localparam int SEL_W           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int NUM_PAGES       = (XLEN + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
   localparam int PAGE_W          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
   input  logic                    CLOCK_50,
   input  logic                    reset_n,
   input  logic [SEL_W-1:0]        reg_sel,
   input  logic                    freeze,
   input  logic                    page_btn_n,
   output logic [SEL_W-1:0]        rd_addr,
   input  logic [XLEN-1:0]         rd_data,
   output logic [7*NUM_DIGITS-1:0] hex,
   output logic [LED_WIDTH-1:0]    leds,
   output logic [PAGE_W-1:0]       page
);

   localparam int NUM_NIBBLES = XLEN / 4;
   localparam int CNT_W       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [6:0] BLANK = 7'b1111111;

   logic [1:0]              sync_reg;
   logic                    stable_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic [PAGE_W-1:0]       page_reg;
   logic [XLEN-1:0]         snap_reg;
   logic                    press_pulse;
   logic [7*NUM_DIGITS-1:0] hex_next;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Nibbles past the top of the register word render as a blank digit.
   function automatic logic [6:0] digit_code(input logic [XLEN-1:0] v, input int idx);
      logic [6:0] s;
      s = BLANK;
      for (int n = 0; n < NUM_NIBBLES; n++) begin
         if (idx == n) s = seg7(v[n*4 +: 4]);
      end
      return s;
   endfunction

   assign rd_addr = reg_sel;
   assign page    = page_reg;

   // Debouncer runs on the second synchronizer flop only; stable idles high.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg   <= 2'b11;
         stable_reg <= 1'b1;
         cnt_reg    <= '0;
      end else begin
         sync_reg <= {sync_reg[0], page_btn_n};
         if (sync_reg[1] == stable_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == LAST_CNT) begin
            stable_reg <= sync_reg[1];
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // Fires on the same edge that the stable level falls, so exactly once per press.
   assign press_pulse = stable_reg & ~sync_reg[1] & (cnt_reg == LAST_CNT);

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         page_reg <= '0;
      end else if (press_pulse) begin
         if (page_reg == PAGE_W'(NUM_PAGES - 1)) page_reg <= '0;
         else                                    page_reg <= page_reg + PAGE_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)     snap_reg <= '0;
      else if (!freeze) snap_reg <= rd_data;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign hex_next[gi*7 +: 7] = digit_code(snap_reg, int'(page_reg) * NUM_DIGITS + gi);
      end
   endgenerate

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         hex  <= '1;
         leds <= '0;
      end else begin
         hex  <= hex_next;
         leds <= snap_reg[LED_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_hart_display.sv
// Directed bench for hart_display: table of register values on page 0, then
// hand sequences for debounce, paging, freeze and reset corner cases.
module tb_hart_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] BL = 7'b1111111;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  reg_sel = 5'd0;
   logic        freeze = 1'b0;
   logic        page_btn_n = 1'b1;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [41:0] hex;
   logic [9:0]  leds;
   logic [0:0]  page;

   logic [31:0] regs [32];
   assign rd_data = regs[rd_addr];

   always #5 CLOCK_50 = ~CLOCK_50;

   hart_display #(
      .XLEN(32), .NUM_REGS(32), .NUM_DIGITS(6), .LED_WIDTH(10), .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .reg_sel(reg_sel), .freeze(freeze),
      .page_btn_n(page_btn_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .hex(hex), .leds(leds), .page(page)
   );

   typedef struct packed {
      logic [4:0]  sel;
      logic [31:0] data;
      logic [41:0] hex;
      logic [9:0]  led;
   } vec_t;

   vec_t vecs [7];
   int   passed = 0;
   int   total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic press();
      page_btn_n = 1'b0;
      tick(10);
      page_btn_n = 1'b1;
      tick(10);
   endtask

   initial begin
      vecs[0] = '{5'd0, 32'h12345678, {S3, S4, S5, S6, S7, S8}, 10'h278};
      vecs[1] = '{5'd1, 32'hDEADBEEF, {SA, SD, SB, SE, SE, SF}, 10'h2EF};
      vecs[2] = '{5'd2, 32'h00000000, {S0, S0, S0, S0, S0, S0}, 10'h000};
      vecs[3] = '{5'd3, 32'hFFFFFFFF, {SF, SF, SF, SF, SF, SF}, 10'h3FF};
      vecs[4] = '{5'd4, 32'h9ABC0123, {SB, SC, S0, S1, S2, S3}, 10'h123};
      vecs[5] = '{5'd5, 32'h89ABCDEF, {SA, SB, SC, SD, SE, SF}, 10'h1EF};
      vecs[6] = '{5'd6, 32'h76543210, {S5, S4, S3, S2, S1, S0}, 10'h210};
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      for (int k = 0; k < 7; k++) regs[vecs[k].sel] = vecs[k].data;

      // Reset, then release and wait the two-cycle display latency
      tick(3);
      check("rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
      check("rst_leds", 64'(leds), 64'h0);
      check("rst_page", 64'(page), 64'h0);
      reset_n = 1'b1;
      tick(2);
      check("rel_hex", 64'(hex), 64'({S3, S4, S5, S6, S7, S8}));
      check("rel_leds", 64'(leds), 64'h278);

      for (int k = 0; k < 7; k++) begin
         reg_sel = vecs[k].sel;
         #1;
         check($sformatf("vec%0d_rd_addr", k), 64'(rd_addr), 64'(vecs[k].sel));
         tick(2);
         check($sformatf("vec%0d_hex", k), 64'(hex), 64'(vecs[k].hex));
         check($sformatf("vec%0d_leds", k), 64'(leds), 64'(vecs[k].led));
      end

      // First press: exact debounce latency (2 sync + 4 stable cycles)
      reg_sel = 5'd0;
      tick(2);
      page_btn_n = 1'b0;
      tick(5);
      check("deb_early", 64'(page), 64'h0);
      tick(1);
      check("deb_fire", 64'(page), 64'h1);
      tick(4);
      check("held_page", 64'(page), 64'h1);
      check("page1_hex", 64'(hex), 64'({BL, BL, BL, BL, S1, S2}));
      page_btn_n = 1'b1;
      tick(10);
      check("one_press", 64'(page), 64'h1);
      press();
      check("wrap_page", 64'(page), 64'h0);
      check("wrap_hex", 64'(hex), 64'({S3, S4, S5, S6, S7, S8}));

      // Short glitch is rejected
      page_btn_n = 1'b0;
      tick(3);
      page_btn_n = 1'b1;
      tick(10);
      check("short_press", 64'(page), 64'h0);

      // Page 1 of another register
      press();
      reg_sel = 5'd4;
      tick(2);
      check("p1_9abc_hex", 64'(hex), 64'({BL, BL, BL, BL, S9, SA}));
      check("p1_9abc_leds", 64'(leds), 64'h123);
      press();
      check("p1_back", 64'(page), 64'h0);

      // Freeze holds the snapshot through data, select and page changes
      reg_sel = 5'd0;
      tick(2);
      freeze = 1'b1;
      regs[0] = 32'hDEADBEEF;
      tick(3);
      check("frz_hex", 64'(hex), 64'({S3, S4, S5, S6, S7, S8}));
      check("frz_leds", 64'(leds), 64'h278);
      reg_sel = 5'd6;
      tick(3);
      check("frz_sel_hex", 64'(hex), 64'({S3, S4, S5, S6, S7, S8}));
      check("frz_sel_leds", 64'(leds), 64'h278);
      press();
      check("frz_page", 64'(page), 64'h1);
      check("frz_p1_hex", 64'(hex), 64'({BL, BL, BL, BL, S1, S2}));
      check("frz_p1_leds", 64'(leds), 64'h278);
      press();
      check("frz_page0", 64'(page), 64'h0);
      reg_sel = 5'd0;
      freeze = 1'b0;
      tick(1);
      check("unfrz_lat1", 64'(hex), 64'({S3, S4, S5, S6, S7, S8}));
      tick(1);
      check("unfrz_hex", 64'(hex), 64'({SA, SD, SB, SE, SE, SF}));
      check("unfrz_leds", 64'(leds), 64'h2EF);

      // Asynchronous reset takes effect before the next clock edge
      press();
      check("pre_rst_page", 64'(page), 64'h1);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
      check("async_leds", 64'(leds), 64'h0);
      check("async_page", 64'(page), 64'h0);
      tick(2);
      reset_n = 1'b1;
      tick(3);

      // Reset mid-debounce discards the pending press
      page_btn_n = 1'b0;
      tick(2);
      reset_n = 1'b0;
      tick(2);
      page_btn_n = 1'b1;
      tick(1);
      reset_n = 1'b1;
      tick(12);
      check("mid_rst_page", 64'(page), 64'h0);
      check("mid_rst_hex", 64'(hex), 64'({SA, SD, SB, SE, SE, SF}));

      // Counter one step from firing, then reset: a held button must restart the full count
      page_btn_n = 1'b0;
      tick(5);
      check("near_fire_page", 64'(page), 64'h0);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(5);
      check("restart_early", 64'(page), 64'h0);
      tick(1);
      check("restart_fire", 64'(page), 64'h1);
      page_btn_n = 1'b1;
      tick(10);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
